lpm_ram_io_arbiter: RTL and testbench

//  Two-requester controller that shares one single-port bidirectional RAM (lpm_ram_io, all REGISTERED,

---
 rtl/lpm_ram_io_arbiter_pkg.sv | 29 ++
 rtl/lpm_ram_io_arbiter_if.sv | 28 ++
 rtl/lpm_ram_io_arbiter_rr_arb2.sv | 41 ++++
 rtl/lpm_ram_io_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_lpm_ram_io_arbiter.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lpm_ram_io_arbiter_pkg.sv
// Shared types for the lpm_ram_io arbiter.
//   state_e : controller FSM states (one RAM transaction per pass away from StIdle)
//   owner_e : which requester owns the transaction in flight
package lpm_ram_io_arbiter_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StWrite  = 3'd1,
    StRdAddr = 3'd2,
    StRdWait = 3'd3,
    StRdCapt = 3'd4
  } state_e;

  typedef enum logic {
    OwnA = 1'b0,
    OwnB = 1'b1
  } owner_e;

  // The RAM output register is loaded and presented on ram_dio in these states.
  function automatic logic is_read_out(input state_e s);
    return (s == StRdWait) || (s == StRdCapt);
  endfunction

  // Any non-idle state holds the RAM enabled.
  function automatic logic is_ram_active(input state_e s);
    return s != StIdle;
  endfunction

endpackage

// File: rtl/lpm_ram_io_arbiter_if.sv
// Requester bus for one port of the lpm_ram_io arbiter.
//   master : bus master side (drives req/we/address/data, receives gnt/q/rvalid)
//   slave  : arbiter side
// req/we/address/data must be held stable until gnt is seen.
interface lpm_ram_io_arbiter_if #(
  parameter int unsigned Width     = 8,
  parameter int unsigned AddrWidth = 8
);

  logic                 req;
  logic                 we;
  logic [AddrWidth-1:0] address;
  logic [Width-1:0]     data;
  logic                 gnt;
  logic [Width-1:0]     q;
  logic                 rvalid;

  modport master (
    output req, we, address, data,
    input  gnt, q, rvalid
  );

  modport slave (
    input  req, we, address, data,
    output gnt, q, rvalid
  );

endinterface

// File: rtl/lpm_ram_io_arbiter_rr_arb2.sv
// Two-way round-robin arbiter.
//   clk_i, rst_ni : clock, async active-low reset (priority resets to requester 0)
//   req_i[1:0]    : request vector (bit 0 = A, bit 1 = B)
//   advance_i     : grant is being consumed this cycle; update the pointer
//   grant_o[1:0]  : one-hot combinational grant (zero when no request)
module lpm_ram_io_arbiter_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  // ptr_q = 1 means requester 1 wins the next tie.
  logic ptr_q, ptr_d;

  always_comb begin
    grant_o = 2'b00;
    unique case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase

    ptr_d = ptr_q;
    // Priority goes to whoever was not granted last.
    if (advance_i && (grant_o != 2'b00)) begin
      ptr_d = grant_o[0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/lpm_ram_io_arbiter.sv
// Shares one registered single-port bidirectional RAM (lpm_ram_io) between two requesters.
//   clock, aclr_n      : clock (rising edge), asynchronous active-low reset
//   a_if, b_if         : requester buses (slave side); gnt/rvalid are 1-cycle pulses
//   err                : pulses with gnt when the accepted address is out of range
//   busy               : FSM away from idle
//   ram_address, ram_we, ram_memenab, ram_outenab : RAM control pins
//   ram_dio            : RAM data pins; driven only while writing, otherwise released
// Writes take 2 cycles (StWrite, StIdle); reads take 4 (StRdAddr, StRdWait, StRdCapt, StIdle).
// All outputs, including the ram_dio drive enable, come straight from flops.
module lpm_ram_io_arbiter
  import lpm_ram_io_arbiter_pkg::*;
#(
  parameter int unsigned LPM_WIDTH    = 8,
  parameter int unsigned LPM_WIDTHAD  = 8,
  parameter int unsigned LPM_NUMWORDS = 1 << LPM_WIDTHAD
) (
  input  logic                   clock,
  input  logic                   aclr_n,
  lpm_ram_io_arbiter_if.slave    a_if,
  lpm_ram_io_arbiter_if.slave    b_if,
  output logic                   err,
  output logic                   busy,
  output logic [LPM_WIDTHAD-1:0] ram_address,
  output logic                   ram_we,
  output logic                   ram_memenab,
  output logic                   ram_outenab,
  inout  wire  [LPM_WIDTH-1:0]   ram_dio
);

  localparam int unsigned Width = LPM_WIDTH;
  localparam int unsigned AddrW = LPM_WIDTHAD;

  function automatic logic addr_ok(input logic [AddrW-1:0] a);
    return 32'(a) < LPM_NUMWORDS;
  endfunction

  state_e             state_q, state_d;
  owner_e             owner_q, owner_d;
  owner_e             sel;
  logic               sel_we;
  logic [AddrW-1:0]   sel_addr;
  logic [Width-1:0]   sel_data;

  logic [1:0]         arb_req, arb_grant;
  logic               arb_adv;

  logic               a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic               a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic [Width-1:0]   a_q_q, a_q_d, b_q_q, b_q_d;
  logic               rej_rd_q, rej_rd_d;

  logic               err_d, busy_d, ram_we_d, ram_memenab_d, ram_outenab_d;
  logic [AddrW-1:0]   ram_address_d;
  logic               dio_oe_q, dio_oe_d;
  logic [Width-1:0]   dio_q, dio_d;

  // A requester whose gnt is showing this cycle may still hold req (it only sees gnt at the
  // end of the cycle); masking it keeps a rejected command from being accepted twice.
  assign arb_req = {b_if.req & ~b_gnt_q, a_if.req & ~a_gnt_q};
  assign arb_adv = (state_q == StIdle);

  lpm_ram_io_arbiter_rr_arb2 u_rr_arb2 (
    .clk_i     (clock),
    .rst_ni    (aclr_n),
    .req_i     (arb_req),
    .advance_i (arb_adv),
    .grant_o   (arb_grant)
  );

  assign sel      = arb_grant[1] ? OwnB : OwnA;
  assign sel_we   = arb_grant[1] ? b_if.we      : a_if.we;
  assign sel_addr = arb_grant[1] ? b_if.address : a_if.address;
  assign sel_data = arb_grant[1] ? b_if.data    : a_if.data;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rej_rd_d      = 1'b0;
    a_gnt_d       = 1'b0;
    b_gnt_d       = 1'b0;
    err_d         = 1'b0;
    a_rvalid_d    = 1'b0;
    b_rvalid_d    = 1'b0;
    a_q_d         = a_q_q;
    b_q_d         = b_q_q;
    ram_address_d = ram_address;
    dio_d         = dio_q;

    // A rejected read completes one cycle after its gnt with zero data.
    if (rej_rd_q) begin
      if (owner_q == OwnB) begin
        b_rvalid_d = 1'b1;
        b_q_d      = '0;
      end else begin
        a_rvalid_d = 1'b1;
        a_q_d      = '0;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (arb_grant != 2'b00) begin
          owner_d = sel;
          a_gnt_d = (sel == OwnA);
          b_gnt_d = (sel == OwnB);
          if (!addr_ok(sel_addr)) begin
            // Out of range: stay idle, no RAM access.
            err_d    = 1'b1;
            rej_rd_d = ~sel_we;
          end else begin
            state_d       = sel_we ? StWrite : StRdAddr;
            ram_address_d = sel_addr;
            if (sel_we) begin
              dio_d = sel_data;
            end
          end
        end
      end
      StWrite:  state_d = StIdle;
      StRdAddr: state_d = StRdWait;
      StRdWait: state_d = StRdCapt;
      StRdCapt: begin
        state_d = StIdle;
        if (owner_q == OwnB) begin
          b_rvalid_d = 1'b1;
          b_q_d      = ram_dio;
        end else begin
          a_rvalid_d = 1'b1;
          a_q_d      = ram_dio;
        end
      end
      default:  state_d = StIdle;
    endcase

    // Pin values for the state being entered, so they are flop outputs in that state.
    busy_d        = (state_d != StIdle);
    ram_we_d      = (state_d == StWrite);
    ram_memenab_d = is_ram_active(state_d);
    ram_outenab_d = is_read_out(state_d);
    dio_oe_d      = (state_d == StWrite);
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q     <= StIdle;
      owner_q     <= OwnA;
      rej_rd_q    <= 1'b0;
      a_gnt_q     <= 1'b0;
      b_gnt_q     <= 1'b0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      a_q_q       <= '0;
      b_q_q       <= '0;
      err         <= 1'b0;
      busy        <= 1'b0;
      ram_address <= '0;
      ram_we      <= 1'b0;
      ram_memenab <= 1'b0;
      ram_outenab <= 1'b0;
      dio_oe_q    <= 1'b0;
      dio_q       <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rej_rd_q    <= rej_rd_d;
      a_gnt_q     <= a_gnt_d;
      b_gnt_q     <= b_gnt_d;
      a_rvalid_q  <= a_rvalid_d;
      b_rvalid_q  <= b_rvalid_d;
      a_q_q       <= a_q_d;
      b_q_q       <= b_q_d;
      err         <= err_d;
      busy        <= busy_d;
      ram_address <= ram_address_d;
      ram_we      <= ram_we_d;
      ram_memenab <= ram_memenab_d;
      ram_outenab <= ram_outenab_d;
      dio_oe_q    <= dio_oe_d;
      dio_q       <= dio_d;
    end
  end

  assign ram_dio = dio_oe_q ? dio_q : {Width{1'bz}};

  assign a_if.gnt    = a_gnt_q;
  assign a_if.rvalid = a_rvalid_q;
  assign a_if.q      = a_q_q;
  assign b_if.gnt    = b_gnt_q;
  assign b_if.rvalid = b_rvalid_q;
  assign b_if.q      = b_q_q;

endmodule

// File: tb/tb_lpm_ram_io_arbiter.sv
// Bench for lpm_ram_io_arbiter with a behavioural registered lpm_ram_io (W=8, WAD=4, 12 words).
module tb_lpm_ram_io_arbiter;

  localparam int unsigned W  = 8;
  localparam int unsigned WA = 4;
  localparam int unsigned NW = 12;

  logic clock = 1'b0;
  logic aclr_n = 1'b0;
  always #5 clock = ~clock;

  lpm_ram_io_arbiter_if #(.Width(W), .AddrWidth(WA)) a_bus ();
  lpm_ram_io_arbiter_if #(.Width(W), .AddrWidth(WA)) b_bus ();

  logic          err, busy, ram_we, ram_memenab, ram_outenab;
  logic [WA-1:0] ram_address;
  wire  [W-1:0]  ram_dio;

  lpm_ram_io_arbiter #(
    .LPM_WIDTH    (W),
    .LPM_WIDTHAD  (WA),
    .LPM_NUMWORDS (NW)
  ) dut (
    .clock       (clock),
    .aclr_n      (aclr_n),
    .a_if        (a_bus),
    .b_if        (b_bus),
    .err         (err),
    .busy        (busy),
    .ram_address (ram_address),
    .ram_we      (ram_we),
    .ram_memenab (ram_memenab),
    .ram_outenab (ram_outenab),
    .ram_dio     (ram_dio)
  );

  // Registered RAM model: inputs registered, write commits the edge after, output register.
  logic          ram_clear;
  logic [W-1:0]  mem [16];
  logic [WA-1:0] r_addr;
  logic          r_we;
  logic [W-1:0]  r_din, r_q;

  always @(posedge clock) begin
    if (ram_clear) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'hEE;
    end else if (r_we) begin
      mem[r_addr] <= r_din;
    end
    r_addr <= ram_address;
    r_we   <= ram_we & ram_memenab;
    r_din  <= ram_dio;
    r_q    <= mem[r_addr];
  end
  assign ram_dio = ram_outenab ? r_q : {W{1'bz}};

  int total = 0;
  int bad   = 0;
  int mon_bad = 0;

  // Controller drives dio only while ram_we is high; that must never meet outenab.
  always @(negedge clock) begin
    if (aclr_n) begin
      if (ram_outenab && ram_we) mon_bad <= mon_bad + 1;
      if (err && !(a_bus.gnt || b_bus.gnt)) mon_bad <= mon_bad + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic port, input logic req, input logic we,
                       input logic [WA-1:0] addr, input logic [W-1:0] data);
    if (port) begin
      b_bus.req = req; b_bus.we = we; b_bus.address = addr; b_bus.data = data;
    end else begin
      a_bus.req = req; a_bus.we = we; a_bus.address = addr; a_bus.data = data;
    end
  endtask

  function automatic logic gnt_of(input logic port);
    return port ? b_bus.gnt : a_bus.gnt;
  endfunction
  function automatic logic rv_of(input logic port);
    return port ? b_bus.rvalid : a_bus.rvalid;
  endfunction
  function automatic logic [W-1:0] q_of(input logic port);
    return port ? b_bus.q : a_bus.q;
  endfunction

  typedef struct {
    logic          port;   // 0 = A, 1 = B
    logic          we;
    logic [WA-1:0] addr;
    logic [W-1:0]  data;
    logic          exp_err;
    logic [W-1:0]  exp_q;
  } vec_t;

  vec_t vecs [14];

  // Waits up to 10 cycles for gnt on port; returns cycles waited.
  task automatic wait_gnt(input logic port, output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!gnt_of(port) && n < 10);
  endtask

  task automatic do_txn(input vec_t v, input int idx);
    int    n;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clock);
    drive(v.port, 1'b1, v.we, v.addr, v.data);
    wait_gnt(v.port, n);
    check({tag, "_gnt_lat"}, n, 1);
    check({tag, "_err"}, err, v.exp_err);
    check({tag, "_busy"}, busy, !v.exp_err);
    check({tag, "_memenab"}, ram_memenab, !v.exp_err);
    drive(v.port, 1'b0, v.we, v.addr, v.data);
    @(negedge clock);
    check({tag, "_gnt_pulse"}, gnt_of(v.port), 0);
    if (!v.we) begin
      n = 1;
      while (!rv_of(v.port) && n < 10) begin
        @(negedge clock);
        n++;
      end
      check({tag, "_rv_lat"}, n, v.exp_err ? 1 : 3);
      check({tag, "_q"}, q_of(v.port), v.exp_q);
      if (v.exp_err) check({tag, "_memenab_rej"}, ram_memenab, 0);
      @(negedge clock);
      check({tag, "_rv_pulse"}, rv_of(v.port), 0);
    end
  endtask

  initial begin
    int n;
    int na, nb, ng, rva, rvb, stray;
    logic order [4];

    vecs[0]  = '{1'b0, 1'b1, 4'h5, 8'hA5, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 1'b0, 4'h5, 8'h00, 1'b0, 8'hA5};
    vecs[2]  = '{1'b1, 1'b0, 4'h1, 8'h00, 1'b0, 8'h11};
    vecs[3]  = '{1'b1, 1'b0, 4'h2, 8'h00, 1'b0, 8'h22};
    vecs[4]  = '{1'b0, 1'b0, 4'h5, 8'h00, 1'b0, 8'hA5};
    vecs[5]  = '{1'b0, 1'b0, 4'hE, 8'h00, 1'b1, 8'h00};
    vecs[6]  = '{1'b1, 1'b1, 4'hE, 8'h99, 1'b1, 8'h00};
    vecs[7]  = '{1'b0, 1'b1, 4'h4, 8'h4D, 1'b0, 8'h00};
    vecs[8]  = '{1'b0, 1'b0, 4'h4, 8'h00, 1'b0, 8'h4D};
    vecs[9]  = '{1'b1, 1'b0, 4'hB, 8'h00, 1'b0, 8'hEE};
    vecs[10] = '{1'b1, 1'b0, 4'hC, 8'h00, 1'b1, 8'h00};
    vecs[11] = '{1'b0, 1'b1, 4'hB, 8'hBB, 1'b0, 8'h00};
    vecs[12] = '{1'b0, 1'b0, 4'hB, 8'h00, 1'b0, 8'hBB};
    vecs[13] = '{1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 8'hEE};

    ram_clear = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_memenab", ram_memenab, 0);
    check("rst_outenab", ram_outenab, 0);
    check("rst_we", ram_we, 0);
    check("rst_addr", ram_address, 0);
    check("rst_gnt", {a_bus.gnt, b_bus.gnt, a_bus.rvalid, b_bus.rvalid, err}, 0);
    aclr_n = 1'b1;
    ram_clear = 1'b0;

    // B back-to-back writes: second gnt two cycles after the first.
    @(negedge clock);
    drive(1'b1, 1'b1, 1'b1, 4'h1, 8'h11);
    wait_gnt(1'b1, n);
    check("b2b_gnt1_lat", n, 1);
    drive(1'b1, 1'b1, 1'b1, 4'h2, 8'h22);
    wait_gnt(1'b1, n);
    check("b2b_gnt_spacing", n, 2);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    @(negedge clock);

    for (int i = 0; i < 14; i++) do_txn(vecs[i], i);

    // Write 0x3 then read it back with no gap: new data must be returned.
    @(negedge clock);
    drive(1'b0, 1'b1, 1'b1, 4'h3, 8'h3C);
    wait_gnt(1'b0, n);
    check("wr_rd_wgnt", n, 1);
    drive(1'b0, 1'b1, 1'b0, 4'h3, 8'h00);
    wait_gnt(1'b0, n);
    check("wr_rd_rgnt", n, 2);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    n = 0;
    while (!a_bus.rvalid && n < 10) begin
      @(negedge clock);
      n++;
    end
    check("wr_rd_lat", n, 3);
    check("wr_rd_q", a_bus.q, 8'h3C);

    // Reset during RD_WAIT drops the read.
    @(negedge clock);
    drive(1'b0, 1'b1, 1'b0, 4'h5, 8'h00);
    wait_gnt(1'b0, n);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clock);
    check("rst_mid_outenab_before", ram_outenab, 1);
    aclr_n = 1'b0;
    #1;
    check("rst_mid_outenab", ram_outenab, 0);
    check("rst_mid_memenab", ram_memenab, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_addr", ram_address, 0);
    check("rst_mid_q", {a_bus.q, b_bus.q}, 0);
    @(negedge clock);
    aclr_n = 1'b1;
    stray = 0;
    repeat (8) begin
      @(negedge clock);
      if (a_bus.rvalid || b_bus.rvalid || a_bus.gnt || b_bus.gnt || busy) stray++;
    end
    check("rst_mid_no_resp", stray, 0);

    // Both request two reads each: grants alternate starting with A.
    drive(1'b0, 1'b1, 1'b0, 4'h5, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 4'h1, 8'h00);
    na = 0; nb = 0; ng = 0; rva = 0; rvb = 0; n = 0;
    while ((rva < 2 || rvb < 2) && n < 60) begin
      @(negedge clock);
      n++;
      if (a_bus.gnt) begin
        if (ng < 4) order[ng] = 1'b0;
        ng++; na++;
        if (na == 2) a_bus.req = 1'b0;
      end
      if (b_bus.gnt) begin
        if (ng < 4) order[ng] = 1'b1;
        ng++; nb++;
        if (nb == 2) b_bus.req = 1'b0;
      end
      if (a_bus.rvalid) begin
        rva++;
        check("rr_a_q", a_bus.q, 8'hA5);
      end
      if (b_bus.rvalid) begin
        rvb++;
        check("rr_b_q", b_bus.q, 8'h11);
      end
    end
    check("rr_grants", ng, 4);
    check("rr_rvalids", {rva[7:0], rvb[7:0]}, 16'h0202);
    check("rr_order", {order[0], order[1], order[2], order[3]}, 4'b0101);

    repeat (2) @(negedge clock);
    check("monitor", mon_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
